// File: rtl/decoder_nx2n_seq.sv
// decoder_nx2n_seq
//   Registered N-to-2^N one-hot strobe generator with a valid/ready load port.
//   Modes (sampled on acceptance): LEVEL holds the one-hot value until replaced,
//   PULSE holds it for HOLD_CYCLES cycles, SWEEP walks the hot bit upward from
//   sel to the top output, HOLD_CYCLES cycles per position.
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   in_valid       request strobe
//   in_ready       request can be accepted this cycle (combinational)
//   sel            binary select, sampled on acceptance
//   mode           00 LEVEL, 01 PULSE, 10 SWEEP, 11 treated as LEVEL
//   clear          synchronous abort to all-zero output and IDLE
//   out            registered one-hot (or all-zero) output
//   busy           high while a PULSE or SWEEP is running
//   done           one-cycle pulse on normal PULSE/SWEEP completion
module decoder_nx2n_seq #(
   parameter int unsigned N_SEL       = 3,
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N_SEL-1:0]        sel,
   input  logic [1:0]              mode,
   input  logic                    clear,
   output logic [(1<<N_SEL)-1:0]   out,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned        OUT_W       = 1 << N_SEL;
   localparam logic [7:0]         HOLD_RELOAD = 8'(HOLD_CYCLES - 1);
   localparam logic [N_SEL-1:0]   IDX_MAX     = '1;

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } state_e;

   typedef enum logic [1:0] {
      MODE_LEVEL = 2'b00,
      MODE_PULSE = 2'b01,
      MODE_SWEEP = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_e;

   state_e             state_q, state_d;
   logic [OUT_W-1:0]   out_q,   out_d;
   logic [7:0]         cnt_q,   cnt_d;
   logic [N_SEL-1:0]   idx_q,   idx_d;
   logic               sweep_q, sweep_d;
   logic               busy_q,  busy_d;
   logic               done_q,  done_d;

   logic               accept;
   logic [OUT_W-1:0]   sel_onehot;
   mode_e              mode_in;

   always_comb begin
      in_ready = (state_q == ST_IDLE) && !clear && !rst;
      accept   = in_valid && in_ready;
      mode_in  = mode_e'(mode);
   end

   always_comb begin
      sel_onehot      = '0;
      sel_onehot[sel] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sweep_d = sweep_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      if (clear) begin
         state_d = ST_IDLE;
         out_d   = '0;
         cnt_d   = '0;
         idx_d   = '0;
         sweep_d = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // done_q may be high here; accepting now gives back-to-back operation
               if (accept) begin
                  out_d = sel_onehot;
                  idx_d = sel;
                  case (mode_in)
                     MODE_PULSE, MODE_SWEEP: begin
                        state_d = ST_ACTIVE;
                        cnt_d   = HOLD_RELOAD;
                        sweep_d = (mode_in == MODE_SWEEP);
                        busy_d  = 1'b1;
                     end
                     default: begin
                        sweep_d = 1'b0;
                     end
                  endcase
               end
            end
            ST_ACTIVE: begin
               if (cnt_q != 8'd0) begin
                  cnt_d = cnt_q - 8'd1;
               end else if (sweep_q && (idx_q != IDX_MAX)) begin
                  idx_d = idx_q + 1'b1;
                  out_d = {out_q[OUT_W-2:0], 1'b0};
                  cnt_d = HOLD_RELOAD;
               end else begin
                  state_d = ST_IDLE;
                  out_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         out_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         sweep_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sweep_q <= sweep_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      out  = out_q;
      busy = busy_q;
      done = done_q;
   end

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// tb_decoder_nx2n_seq
//   Scoreboard bench: per-cycle expected (out, done, busy, in_ready) tuples are
//   queued as stimulus is planned and compared on the falling edge of each cycle.
//   dut uses HOLD_CYCLES=2; dut_h1 uses HOLD_CYCLES=1 and only sees its own valid.
module tb_decoder_nx2n_seq;

   localparam int unsigned HOLD = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       valid1 = 1'b0;
   logic       clear = 1'b0;
   logic [2:0] sel = '0;
   logic [1:0] mode = '0;

   logic       ready0, busy0, done0;
   logic [7:0] out0;
   logic       ready1, busy1, done1;
   logic [7:0] out1;

   decoder_nx2n_seq #(.N_SEL(3), .HOLD_CYCLES(HOLD)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (ready0),
      .sel      (sel),
      .mode     (mode),
      .clear    (clear),
      .out      (out0),
      .busy     (busy0),
      .done     (done0)
   );

   decoder_nx2n_seq #(.N_SEL(3), .HOLD_CYCLES(1)) dut_h1 (
      .clk      (clk),
      .rst      (rst),
      .in_valid (valid1),
      .in_ready (ready1),
      .sel      (sel),
      .mode     (mode),
      .clear    (clear),
      .out      (out1),
      .busy     (busy1),
      .done     (done1)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         u;
      logic [7:0] out;
      logic       done;
      logic       busy;
      logic       ready;
   } exp_t;

   exp_t  sb[$];
   int    n_vec = 0;
   int    n_err = 0;
   string cur_tag = "reset";

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push(input bit u, input logic [7:0] o, input logic d,
                       input logic b, input logic r);
      exp_t e;
      e.u = u; e.out = o; e.done = d; e.busy = b; e.ready = r;
      sb.push_back(e);
   endtask

   // One clock cycle: compare the oldest expectation at negedge, then advance
   // to just after the next rising edge where stimulus may change.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.u) begin
            chk({cur_tag, ".h1.out"},   32'(out1),   32'(e.out));
            chk({cur_tag, ".h1.done"},  32'(done1),  32'(e.done));
            chk({cur_tag, ".h1.busy"},  32'(busy1),  32'(e.busy));
            chk({cur_tag, ".h1.ready"}, 32'(ready1), 32'(e.ready));
         end else begin
            chk({cur_tag, ".out"},   32'(out0),   32'(e.out));
            chk({cur_tag, ".done"},  32'(done0),  32'(e.done));
            chk({cur_tag, ".busy"},  32'(busy0),  32'(e.busy));
            chk({cur_tag, ".ready"}, 32'(ready0), 32'(e.ready));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // 1: reset
      cur_tag = "reset";
      push(0, 8'h00, 0, 0, 0);
      push(0, 8'h00, 0, 0, 0);
      push(1, 8'h00, 0, 0, 0);
      run(3);
      rst = 1'b0;
      push(0, 8'h00, 0, 0, 1);
      push(1, 8'h00, 0, 0, 1);
      run(2);

      // 2: LEVEL sel=5 held, then LEVEL sel=0
      cur_tag = "level";
      in_valid = 1'b1; sel = 3'd5; mode = 2'b00;
      push(0, 8'h00, 0, 0, 1);
      cycle();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) push(0, 8'b0010_0000, 0, 0, 1);
      run(10);
      in_valid = 1'b1; sel = 3'd0; mode = 2'b00;
      push(0, 8'h20, 0, 0, 1);
      cycle();
      in_valid = 1'b0;
      push(0, 8'h01, 0, 0, 1);
      cycle();

      // 3: PULSE sel=3 replaces held LEVEL, then LEVEL sel=7 in the done cycle
      cur_tag = "pulse";
      in_valid = 1'b1; sel = 3'd3; mode = 2'b01;
      push(0, 8'h01, 0, 0, 1);
      cycle();
      in_valid = 1'b0;
      for (int i = 0; i < HOLD; i++) push(0, 8'h08, 0, 1, 0);
      run(HOLD);
      cur_tag = "b2b";
      in_valid = 1'b1; sel = 3'd7; mode = 2'b00;
      push(0, 8'h00, 1, 0, 1);
      cycle();
      in_valid = 1'b0;
      push(0, 8'h80, 0, 0, 1);
      cycle();

      // 4: SWEEP sel=5 walks to the top bit, no wrap
      cur_tag = "sweep";
      in_valid = 1'b1; sel = 3'd5; mode = 2'b10;
      push(0, 8'h80, 0, 0, 1);
      cycle();
      in_valid = 1'b0;
      for (int k = 5; k < 8; k++)
         for (int h = 0; h < HOLD; h++) push(0, 8'(1 << k), 0, 1, 0);
      push(0, 8'h00, 1, 0, 1);
      push(0, 8'h00, 0, 0, 1);
      run(2 + 3 * HOLD);

      // 5: SWEEP sel=0 aborted by clear alongside in_valid
      cur_tag = "clear";
      in_valid = 1'b1; sel = 3'd0; mode = 2'b10;
      push(0, 8'h00, 0, 0, 1);
      cycle();
      in_valid = 1'b0;
      push(0, 8'h01, 0, 1, 0);
      push(0, 8'h01, 0, 1, 0);
      push(0, 8'h02, 0, 1, 0);
      push(0, 8'h02, 0, 1, 0);
      push(0, 8'h04, 0, 1, 0);
      run(5);
      clear = 1'b1; in_valid = 1'b1; sel = 3'd3; mode = 2'b00;
      push(0, 8'h04, 0, 1, 0);
      cycle();
      clear = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 3; i++) push(0, 8'h00, 0, 0, 1);
      run(3);

      // clear in IDLE over a held LEVEL value with a competing request
      cur_tag = "clear_idle";
      in_valid = 1'b1; sel = 3'd2; mode = 2'b00;
      push(0, 8'h00, 0, 0, 1);
      cycle();
      clear = 1'b1; sel = 3'd6;
      push(0, 8'h04, 0, 0, 0);
      cycle();
      clear = 1'b0; in_valid = 1'b0;
      push(0, 8'h00, 0, 0, 1);
      push(0, 8'h00, 0, 0, 1);
      run(2);

      // 6: HOLD_CYCLES=1 PULSE sel=6, then reset mid-pulse
      cur_tag = "pulse_h1";
      valid1 = 1'b1; sel = 3'd6; mode = 2'b01;
      push(1, 8'h00, 0, 0, 1);
      cycle();
      valid1 = 1'b0;
      push(1, 8'h40, 0, 1, 0);
      push(1, 8'h00, 1, 0, 1);
      push(1, 8'h00, 0, 0, 1);
      run(3);
      cur_tag = "rst_mid";
      valid1 = 1'b1; sel = 3'd6; mode = 2'b01;
      push(1, 8'h00, 0, 0, 1);
      cycle();
      valid1 = 1'b0; rst = 1'b1;
      push(1, 8'h40, 0, 1, 0);
      cycle();
      rst = 1'b0;
      push(1, 8'h00, 0, 0, 1);
      push(1, 8'h00, 0, 0, 1);
      push(0, 8'h00, 0, 0, 1);
      run(3);

      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
